// File: rtl/stream_buffer_reader.sv
// Consumer side of the card-memory stream buffer: splits link descriptors into card
// read requests, tracks them in issue order and replays returned card data as AXI4 stream.
//
//   state    | meaning
//   ST_IDLE  | waiting for a descriptor in the descriptor FIFO
//   ST_ISSUE | issuing chunked read requests for the current region
module stream_buffer_reader #(
   parameter int AXI_STRM_ID     = 0,
   parameter int TRANSFER_SIZE   = 4096,
   parameter int DESC_FIFO_DEPTH = 4,
   parameter int MAX_OUTSTANDING = 8,
   parameter int VADDR_W         = 48,
   parameter int DEST_W          = 4,
   parameter int STRM_W          = 2,
   parameter int STRM_CARD       = 1
) (
   input  logic               clk,
   input  logic               rst,

   input  logic [VADDR_W-1:0] link_vaddr,
   input  logic [31:0]        link_size,
   input  logic               link_last,
   input  logic               link_valid,
   output logic               link_ready,

   output logic [VADDR_W-1:0] sq_rd_vaddr,
   output logic [31:0]        sq_rd_len,
   output logic [STRM_W-1:0]  sq_rd_strm,
   output logic [DEST_W-1:0]  sq_rd_dest,
   output logic               sq_rd_last,
   output logic               sq_rd_valid,
   input  logic               sq_rd_ready,

   input  logic               cq_rd_valid,
   output logic               cq_rd_ready,

   input  logic [511:0]       in_tdata,
   input  logic [63:0]        in_tkeep,
   input  logic               in_tvalid,
   output logic               in_tready,

   output logic [511:0]       out_tdata,
   output logic [63:0]        out_tkeep,
   output logic               out_tlast,
   output logic               out_tvalid,
   input  logic               out_tready
);

   localparam int DA = $clog2(DESC_FIFO_DEPTH);
   localparam int TA = $clog2(MAX_OUTSTANDING);

   typedef enum logic [0:0] {ST_IDLE, ST_ISSUE} state_t;

   state_t               state;
   logic [VADDR_W-1:0]   cur_vaddr;
   logic [31:0]          rem_bytes;
   logic                 cur_last;
   logic                 ready_en;

   logic [VADDR_W-1:0]   desc_vaddr_mem [DESC_FIFO_DEPTH];
   logic [31:0]          desc_size_mem  [DESC_FIFO_DEPTH];
   logic                 desc_last_mem  [DESC_FIFO_DEPTH];
   logic [DA:0]          desc_wr_ptr, desc_rd_ptr;
   logic                 desc_empty, desc_full, desc_push, desc_pop;

   logic [25:0]          trk_beats_mem [MAX_OUTSTANDING];
   logic                 trk_eos_mem   [MAX_OUTSTANDING];
   logic [TA:0]          trk_wr_ptr, trk_rd_ptr, trk_count, trk_count_next;
   logic                 trk_empty, trk_full, trk_push, trk_pop, trk_space_next;
   logic [25:0]          push_beats;
   logic                 push_eos;

   logic [31:0]          chunk;
   logic                 sq_fire, zero_push;
   logic [25:0]          h_beats, beat_cnt;
   logic                 h_eos, h_final, out_fire;
   logic                 unused_cq;

   assign unused_cq   = cq_rd_valid;
   assign cq_rd_ready = 1'b1;

   // Descriptor FIFO
   assign desc_empty = (desc_wr_ptr == desc_rd_ptr);
   assign desc_full  = (desc_wr_ptr[DA] != desc_rd_ptr[DA]) &&
                       (desc_wr_ptr[DA-1:0] == desc_rd_ptr[DA-1:0]);
   assign link_ready = ready_en && !desc_full;
   assign desc_push  = link_valid && link_ready;
   assign desc_pop   = (state == ST_IDLE) && !desc_empty;

   always_ff @(posedge clk) begin
      if (desc_push) begin
         desc_vaddr_mem[desc_wr_ptr[DA-1:0]] <= link_vaddr;
         desc_size_mem[desc_wr_ptr[DA-1:0]]  <= link_size;
         desc_last_mem[desc_wr_ptr[DA-1:0]]  <= link_last;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         desc_wr_ptr <= '0;
         desc_rd_ptr <= '0;
         ready_en    <= 1'b0;
      end else begin
         ready_en <= 1'b1;
         if (desc_push) desc_wr_ptr <= desc_wr_ptr + 1'b1;
         if (desc_pop)  desc_rd_ptr <= desc_rd_ptr + 1'b1;
      end
   end

   // Request generation
   assign chunk       = (rem_bytes > 32'(TRANSFER_SIZE)) ? 32'(TRANSFER_SIZE) : rem_bytes;
   assign sq_rd_vaddr = cur_vaddr;
   assign sq_rd_len   = chunk;
   assign sq_rd_strm  = STRM_W'(STRM_CARD);
   assign sq_rd_dest  = DEST_W'(AXI_STRM_ID);
   assign sq_rd_last  = 1'b1;
   assign sq_fire     = sq_rd_valid && sq_rd_ready;

   // A zero-size region marked last still owes the consumer one tlast marker.
   assign zero_push  = (state == ST_ISSUE) && (rem_bytes == '0) && cur_last && !trk_full;
   assign trk_push   = sq_fire || zero_push;
   assign push_beats = zero_push ? 26'd0 : (chunk[31:6] + {25'd0, |chunk[5:0]});
   assign push_eos   = zero_push ? 1'b1 : (cur_last && (rem_bytes == chunk));

   // sq_rd_valid is decided from next-cycle occupancy so a raised request always has room
   assign trk_count      = trk_wr_ptr - trk_rd_ptr;
   assign trk_empty      = (trk_count == '0);
   assign trk_full       = (trk_count == (TA+1)'(MAX_OUTSTANDING));
   assign trk_count_next = trk_count + (TA+1)'(trk_push) - (TA+1)'(trk_pop);
   assign trk_space_next = (trk_count_next < (TA+1)'(MAX_OUTSTANDING));

   always_ff @(posedge clk) begin
      if (rst) begin
         state       <= ST_IDLE;
         cur_vaddr   <= '0;
         rem_bytes   <= '0;
         cur_last    <= 1'b0;
         sq_rd_valid <= 1'b0;
      end else begin
         case (state)
            ST_IDLE: begin
               if (!desc_empty) begin
                  cur_vaddr   <= desc_vaddr_mem[desc_rd_ptr[DA-1:0]];
                  rem_bytes   <= desc_size_mem[desc_rd_ptr[DA-1:0]];
                  cur_last    <= desc_last_mem[desc_rd_ptr[DA-1:0]];
                  sq_rd_valid <= (desc_size_mem[desc_rd_ptr[DA-1:0]] != '0) && trk_space_next;
                  state       <= ST_ISSUE;
               end
            end
            ST_ISSUE: begin
               if (rem_bytes == '0) begin
                  if (!cur_last || !trk_full) state <= ST_IDLE;
               end else if (sq_fire) begin
                  cur_vaddr <= cur_vaddr + VADDR_W'(chunk);
                  rem_bytes <= rem_bytes - chunk;
                  if (rem_bytes == chunk) begin
                     sq_rd_valid <= 1'b0;
                     state       <= ST_IDLE;
                  end else begin
                     sq_rd_valid <= trk_space_next;
                  end
               end else begin
                  sq_rd_valid <= trk_space_next;
               end
            end
            default: state <= ST_IDLE;
         endcase
      end
   end

   // Tracking FIFO
   always_ff @(posedge clk) begin
      if (trk_push) begin
         trk_beats_mem[trk_wr_ptr[TA-1:0]] <= push_beats;
         trk_eos_mem[trk_wr_ptr[TA-1:0]]   <= push_eos;
      end
   end

   assign h_beats = trk_beats_mem[trk_rd_ptr[TA-1:0]];
   assign h_eos   = trk_eos_mem[trk_rd_ptr[TA-1:0]];
   assign h_final = (beat_cnt == h_beats - 26'd1);

   always_comb begin
      out_tdata  = '0;
      out_tkeep  = '0;
      out_tlast  = 1'b0;
      out_tvalid = 1'b0;
      in_tready  = 1'b0;
      if (!trk_empty) begin
         if (h_beats == '0) begin
            out_tvalid = 1'b1;
            out_tlast  = 1'b1;
         end else begin
            out_tdata  = in_tdata;
            out_tkeep  = in_tkeep;
            out_tvalid = in_tvalid;
            out_tlast  = h_eos && h_final;
            in_tready  = out_tready;
         end
      end
   end

   assign out_fire = out_tvalid && out_tready;
   assign trk_pop  = out_fire && ((h_beats == '0) || h_final);

   always_ff @(posedge clk) begin
      if (rst) begin
         trk_wr_ptr <= '0;
         trk_rd_ptr <= '0;
         beat_cnt   <= '0;
      end else begin
         if (trk_push) trk_wr_ptr <= trk_wr_ptr + 1'b1;
         if (trk_pop) begin
            trk_rd_ptr <= trk_rd_ptr + 1'b1;
            beat_cnt   <= '0;
         end else if (out_fire) begin
            beat_cnt <= beat_cnt + 26'd1;
         end
      end
   end

endmodule

// File: tb/tb_stream_buffer_reader.sv
// Bench for stream_buffer_reader: directed steps plus randomized traffic checked
// against a queue-based model of region splitting and stream replay.
module tb_stream_buffer_reader;

   localparam int TS = 256;
   localparam int VW = 48;
   localparam int NW = 2048;

   logic          clk = 1'b0;
   logic          rst;
   logic [VW-1:0] link_vaddr;
   logic [31:0]   link_size;
   logic          link_last, link_valid, link_ready;
   logic [VW-1:0] sq_rd_vaddr;
   logic [31:0]   sq_rd_len;
   logic [1:0]    sq_rd_strm;
   logic [3:0]    sq_rd_dest;
   logic          sq_rd_last, sq_rd_valid, sq_rd_ready;
   logic          cq_rd_valid, cq_rd_ready;
   logic [511:0]  in_tdata, out_tdata;
   logic [63:0]   in_tkeep, out_tkeep;
   logic          in_tvalid, in_tready, out_tlast, out_tvalid, out_tready;

   always #5 clk = ~clk;

   stream_buffer_reader #(
      .AXI_STRM_ID(0), .TRANSFER_SIZE(TS), .DESC_FIFO_DEPTH(4), .MAX_OUTSTANDING(8),
      .VADDR_W(VW), .DEST_W(4), .STRM_W(2), .STRM_CARD(1)
   ) dut (
      .clk(clk), .rst(rst),
      .link_vaddr(link_vaddr), .link_size(link_size), .link_last(link_last),
      .link_valid(link_valid), .link_ready(link_ready),
      .sq_rd_vaddr(sq_rd_vaddr), .sq_rd_len(sq_rd_len), .sq_rd_strm(sq_rd_strm),
      .sq_rd_dest(sq_rd_dest), .sq_rd_last(sq_rd_last), .sq_rd_valid(sq_rd_valid),
      .sq_rd_ready(sq_rd_ready),
      .cq_rd_valid(cq_rd_valid), .cq_rd_ready(cq_rd_ready),
      .in_tdata(in_tdata), .in_tkeep(in_tkeep), .in_tvalid(in_tvalid), .in_tready(in_tready),
      .out_tdata(out_tdata), .out_tkeep(out_tkeep), .out_tlast(out_tlast),
      .out_tvalid(out_tvalid), .out_tready(out_tready)
   );

   typedef struct {logic [VW-1:0] vaddr; logic [31:0] size; bit last;} desc_t;
   typedef struct {logic [VW-1:0] vaddr; logic [31:0] len;} req_t;
   typedef struct {bit zero; bit last;} slot_t;

   desc_t        to_send[$];
   req_t         exp_req[$];
   slot_t        exp_slot[$];
   logic [511:0] words [NW];
   logic [63:0]  keeps [NW];
   int           in_idx = 0, out_idx = 0;
   int           checks = 0, failures = 0;
   int           n_sq = 0, n_out = 0, n_tlast = 0, n_link = 0, n_last_desc = 0;
   int           p_in = 100, p_out = 100, p_sq = 100;
   bit           in_en = 1'b1;

   task automatic check(input string tag, input logic [511:0] obs, input logic [511:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Expected requests and output beats follow directly from region size and last flag.
   function automatic void model_desc(input desc_t d);
      logic [VW-1:0] a = d.vaddr;
      logic [31:0]   r = d.size;
      logic [31:0]   c;
      int            nb;
      if (d.last) n_last_desc++;
      if (r == 0 && d.last) exp_slot.push_back('{1'b1, 1'b1});
      while (r != 0) begin
         c  = (r > TS) ? TS : r;
         nb = (int'(c) + 63) / 64;
         exp_req.push_back('{a, c});
         for (int k = 0; k < nb; k++)
            exp_slot.push_back('{1'b0, d.last && (r == c) && (k == nb - 1)});
         a = a + VW'(c);
         r = r - c;
      end
   endfunction

   task automatic drive();
      link_valid = (to_send.size() > 0);
      if (link_valid) begin
         link_vaddr = to_send[0].vaddr;
         link_size  = to_send[0].size;
         link_last  = to_send[0].last;
      end
      in_tvalid   = in_en && (in_idx < NW) && ($urandom_range(99) < p_in);
      in_tdata    = words[in_idx % NW];
      in_tkeep    = keeps[in_idx % NW];
      out_tready  = ($urandom_range(99) < p_out);
      sq_rd_ready = ($urandom_range(99) < p_sq);
      cq_rd_valid = $urandom_range(1);
   endtask

   task automatic tick();
      req_t  r;
      slot_t s;
      #1;
      if (!rst) begin
         if (link_valid && link_ready) begin
            model_desc(to_send.pop_front());
            n_link++;
         end
         if (sq_rd_valid && sq_rd_ready) begin
            n_sq++;
            check("sq_expected", exp_req.size() != 0, 1'b1);
            if (exp_req.size() != 0) begin
               r = exp_req.pop_front();
               check("sq_vaddr", sq_rd_vaddr, r.vaddr);
               check("sq_len", sq_rd_len, r.len);
               check("sq_strm", sq_rd_strm, 2'd1);
               check("sq_dest", sq_rd_dest, 4'd0);
               check("sq_last", sq_rd_last, 1'b1);
            end
         end
         if (in_tvalid && in_tready) in_idx++;
         if (out_tvalid && out_tready) begin
            n_out++;
            if (out_tlast) n_tlast++;
            check("out_expected", exp_slot.size() != 0, 1'b1);
            if (exp_slot.size() != 0) begin
               s = exp_slot.pop_front();
               if (s.zero) begin
                  check("zero_tdata", out_tdata, '0);
                  check("zero_tkeep", out_tkeep, '0);
                  check("zero_tlast", out_tlast, 1'b1);
               end else begin
                  check("out_tdata", out_tdata, words[out_idx % NW]);
                  check("out_tkeep", out_tkeep, keeps[out_idx % NW]);
                  check("out_tlast", out_tlast, s.last);
                  out_idx++;
               end
            end
         end
      end
      @(posedge clk);
      @(negedge clk);
   endtask

   task automatic run_until_done(input int budget, input string tag);
      int n = 0;
      while ((to_send.size() + exp_req.size() + exp_slot.size()) != 0 && n < budget) begin
         drive();
         tick();
         n++;
      end
      check({tag, "_done_in_budget"}, n < budget, 1'b1);
   endtask

   initial begin
      int sq0, out0, tl0, lk0, ld0, beats, wait_n;
      desc_t d;
      for (int i = 0; i < NW; i++) begin
         words[i] = {16{$urandom()}} ^ {$urandom(), 480'd0} ^ 512'(i);
         keeps[i] = {$urandom(), $urandom()};
      end
      rst = 1'b1; link_valid = 0; link_vaddr = '0; link_size = '0; link_last = 0;
      sq_rd_ready = 0; cq_rd_valid = 0; in_tvalid = 0; in_tdata = '0; in_tkeep = '0;
      out_tready = 0;
      @(negedge clk);
      tick(); tick();
      in_tvalid = 1'b1;
      #1;
      check("rst_link_ready", link_ready, 1'b0);
      check("rst_sq_valid", sq_rd_valid, 1'b0);
      check("rst_in_tready", in_tready, 1'b0);
      check("rst_out_tvalid", out_tvalid, 1'b0);
      check("rst_out_tlast", out_tlast, 1'b0);
      rst = 1'b0; in_tvalid = 1'b0;
      tick();
      check("link_ready_after_rst", link_ready, 1'b1);

      // two full chunks, latency from descriptor acceptance to first request
      sq0 = n_sq; out0 = n_out; tl0 = n_tlast;
      to_send.push_back('{48'h1000, 2 * TS, 1'b1});
      drive(); tick();
      check("desc_accepted", n_link, 1);
      drive();
      #1;
      check("sq_valid_n1", sq_rd_valid, 1'b0);
      check("in_tready_no_entry", in_tready, 1'b0);
      tick();
      check("sq_valid_n2", sq_rd_valid, 1'b1);
      run_until_done(200, "two_chunks");
      check("two_chunks_sq", n_sq - sq0, 2);
      check("two_chunks_beats", n_out - out0, 2 * TS / 64);
      check("two_chunks_tlast", n_tlast - tl0, 1);

      // unaligned sizes split across two descriptors
      p_in = 70; p_out = 70; p_sq = 70;
      sq0 = n_sq; out0 = n_out; tl0 = n_tlast;
      to_send.push_back('{48'h2000, 32'd100, 1'b0});
      to_send.push_back('{48'h3000, 32'd28, 1'b1});
      run_until_done(300, "odd_sizes");
      check("odd_sizes_sq", n_sq - sq0, 2);
      check("odd_sizes_beats", n_out - out0, 3);
      check("odd_sizes_tlast", n_tlast - tl0, 1);

      // zero-size descriptors
      p_in = 100; p_out = 100; p_sq = 100;
      sq0 = n_sq; out0 = n_out; tl0 = n_tlast;
      to_send.push_back('{48'h4000, 32'd0, 1'b1});
      run_until_done(100, "zero_last");
      check("zero_last_sq", n_sq - sq0, 0);
      check("zero_last_beats", n_out - out0, 1);
      check("zero_last_tlast", n_tlast - tl0, 1);
      sq0 = n_sq; out0 = n_out;
      to_send.push_back('{48'h5000, 32'd0, 1'b0});
      run_until_done(100, "zero_nolast");
      for (int i = 0; i < 6; i++) begin drive(); tick(); end
      check("zero_nolast_sq", n_sq - sq0, 0);
      check("zero_nolast_beats", n_out - out0, 0);

      // outstanding limit with card data withheld
      in_en = 1'b0;
      sq0 = n_sq; out0 = n_out; tl0 = n_tlast; lk0 = n_link;
      for (int i = 0; i < 20; i++)
         to_send.push_back('{48'h10000 + 48'(64 * i), 32'd64, i == 19});
      for (int i = 0; i < 40; i++) begin drive(); tick(); end
      check("limit_sq_issued", n_sq - sq0, 8);
      check("limit_desc_accepted", n_link - lk0, 13);
      check("limit_link_ready", link_ready, 1'b0);
      in_en = 1'b1;
      run_until_done(400, "limit_drain");
      check("limit_total_sq", n_sq - sq0, 20);
      check("limit_total_beats", n_out - out0, 20);
      check("limit_tlast", n_tlast - tl0, 1);

      // address wrap then random traffic under backpressure
      p_in = 60; p_out = 60; p_sq = 70;
      tl0 = n_tlast; ld0 = n_last_desc;
      to_send.push_back('{48'hFFFF_FFFF_FF00, 2 * TS, 1'b1});
      beats = 0;
      while (beats < 1000) begin
         d.vaddr = {$urandom(), $urandom()};
         d.size  = ($urandom_range(9) == 0) ? 32'd0 : 32'($urandom_range(700, 1));
         d.last  = $urandom_range(1);
         beats  += (int'(d.size) + 63) / 64;
         to_send.push_back(d);
      end
      run_until_done(30000, "random");
      check("random_tlast_count", n_tlast - tl0, n_last_desc - ld0);
      check("random_no_drop_dup", out_idx, in_idx);

      // reset with requests outstanding
      p_in = 100; p_out = 100; p_sq = 100; in_en = 1'b0;
      sq0 = n_sq;
      for (int i = 0; i < 3; i++)
         to_send.push_back('{48'h7000 + 48'(128 * i), 32'd128, 1'b1});
      wait_n = 0;
      while (n_sq - sq0 < 3 && wait_n < 50) begin drive(); tick(); wait_n++; end
      check("pre_rst_outstanding", n_sq - sq0, 3);
      rst = 1'b1; in_tvalid = 1'b1; out_tready = 1'b1;
      tick();
      in_tvalid = 1'b1;
      #1;
      check("midrst_link_ready", link_ready, 1'b0);
      check("midrst_sq_valid", sq_rd_valid, 1'b0);
      check("midrst_in_tready", in_tready, 1'b0);
      check("midrst_out_tvalid", out_tvalid, 1'b0);
      check("midrst_out_tlast", out_tlast, 1'b0);
      to_send.delete(); exp_req.delete(); exp_slot.delete();
      out_idx = in_idx;
      rst = 1'b0; in_tvalid = 1'b0;
      tick();
      in_en = 1'b1;
      sq0 = n_sq; tl0 = n_tlast;
      to_send.push_back('{48'hABC000, 32'd128, 1'b1});
      run_until_done(100, "post_rst");
      check("post_rst_sq", n_sq - sq0, 1);
      check("post_rst_tlast", n_tlast - tl0, 1);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
